// File: rtl/cpu_control_unit.sv
// Instruction sequencer for the 8-bit CPU: fetches 2-byte instructions over a
// req/ready handshake, decodes them and strobes the register file and PC.
module cpu_control_unit #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic [7:0]  pc_value,
   output logic        mem_req,
   output logic [7:0]  mem_addr,
   input  logic        mem_ready,
   input  logic [7:0]  mem_rdata,
   output logic        pc_enable,
   output logic        pc_jump,
   output logic        pc_jz,
   output logic [7:0]  pc_jump_address,
   output logic [1:0]  alu_op,
   output logic [3:0]  reg_sel,
   output logic [7:0]  imm,
   output logic        reg_write,
   output logic        halted,
   output logic        fault,
   output logic        illegal,
   output logic [15:0] retired_count
);

   localparam int unsigned WAIT_W = 8;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_SUB  = 4'h3;
   localparam logic [3:0] OP_JMP  = 4'h4;
   localparam logic [3:0] OP_JZ   = 4'h5;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH0, S_FETCH1, S_EXECUTE, S_ADVANCE, S_HALTED, S_FAULT
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        opcode_q, opcode_d;
   logic [7:0]        operand_q, operand_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [15:0]       retired_q, retired_d;

   logic       mem_req_q, mem_req_d;
   logic       pc_enable_q, pc_enable_d;
   logic       pc_jump_q, pc_jump_d;
   logic       pc_jz_q, pc_jz_d;
   logic [7:0] pc_jump_address_q, pc_jump_address_d;
   logic [1:0] alu_op_q, alu_op_d;
   logic [3:0] reg_sel_q, reg_sel_d;
   logic [7:0] imm_q, imm_d;
   logic       reg_write_q, reg_write_d;
   logic       halted_q, halted_d;
   logic       fault_q, fault_d;
   logic       illegal_q, illegal_d;
   logic [3:0] op_d;

   // Sequencing, byte latches, fetch timeout and retire counter
   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      operand_d = operand_q;
      wait_d    = wait_q;
      retired_d = retired_q;
      unique case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d = S_FETCH0;
               wait_d  = '0;
            end
         end
         S_FETCH0, S_FETCH1: begin
            if (mem_ready) begin
               wait_d = '0;
               if (state_q == S_FETCH0) begin
                  opcode_d = mem_rdata;
                  state_d  = S_FETCH1;
               end else begin
                  operand_d = mem_rdata;
                  state_d   = S_EXECUTE;
               end
            end else if (wait_q == WAIT_LAST) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_EXECUTE: state_d = (opcode_q[7:4] == OP_HALT) ? S_HALTED : S_ADVANCE;
         S_ADVANCE: begin
            retired_d = retired_q + 16'd1;
            wait_d    = '0;
            state_d   = run ? S_FETCH0 : S_IDLE;
         end
         S_HALTED: state_d = S_HALTED;
         S_FAULT:  state_d = S_FAULT;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it
   always_comb begin
      mem_req_d         = 1'b0;
      pc_enable_d       = 1'b0;
      pc_jump_d         = 1'b0;
      pc_jz_d           = 1'b0;
      pc_jump_address_d = '0;
      alu_op_d          = 2'b00;
      reg_sel_d         = '0;
      imm_d             = '0;
      reg_write_d       = 1'b0;
      halted_d          = 1'b0;
      fault_d           = 1'b0;
      illegal_d         = 1'b0;
      op_d              = opcode_d[7:4];
      unique case (state_d)
         S_FETCH0, S_FETCH1: mem_req_d = 1'b1;
         S_EXECUTE: begin
            reg_sel_d = opcode_d[3:0];
            imm_d     = operand_d;
            unique case (op_d)
               OP_LDI: reg_write_d = 1'b1;
               OP_ADD: begin
                  reg_write_d = 1'b1;
                  alu_op_d    = 2'b01;
               end
               OP_SUB: begin
                  reg_write_d = 1'b1;
                  alu_op_d    = 2'b10;
               end
               OP_NOP, OP_JMP, OP_JZ, OP_HALT: ;
               default: illegal_d = 1'b1;
            endcase
         end
         S_ADVANCE: begin
            pc_enable_d = 1'b1;
            pc_jump_d   = (op_d == OP_JMP);
            pc_jz_d     = (op_d == OP_JZ);
            if ((op_d == OP_JMP) || (op_d == OP_JZ)) begin
               pc_jump_address_d = {operand_d[7:1], 1'b0};
            end
         end
         S_HALTED: halted_d = 1'b1;
         S_FAULT:  fault_d  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q           <= S_IDLE;
         opcode_q          <= '0;
         operand_q         <= '0;
         wait_q            <= '0;
         retired_q         <= '0;
         mem_req_q         <= 1'b0;
         pc_enable_q       <= 1'b0;
         pc_jump_q         <= 1'b0;
         pc_jz_q           <= 1'b0;
         pc_jump_address_q <= '0;
         alu_op_q          <= 2'b00;
         reg_sel_q         <= '0;
         imm_q             <= '0;
         reg_write_q       <= 1'b0;
         halted_q          <= 1'b0;
         fault_q           <= 1'b0;
         illegal_q         <= 1'b0;
      end else begin
         state_q           <= state_d;
         opcode_q          <= opcode_d;
         operand_q         <= operand_d;
         wait_q            <= wait_d;
         retired_q         <= retired_d;
         mem_req_q         <= mem_req_d;
         pc_enable_q       <= pc_enable_d;
         pc_jump_q         <= pc_jump_d;
         pc_jz_q           <= pc_jz_d;
         pc_jump_address_q <= pc_jump_address_d;
         alu_op_q          <= alu_op_d;
         reg_sel_q         <= reg_sel_d;
         imm_q             <= imm_d;
         reg_write_q       <= reg_write_d;
         halted_q          <= halted_d;
         fault_q           <= fault_d;
         illegal_q         <= illegal_d;
      end
   end

   // Address follows the live PC so a fetch right after a jump sees the new target
   always_comb begin
      mem_addr = '0;
      if (state_q == S_FETCH0) begin
         mem_addr = pc_value;
      end else if (state_q == S_FETCH1) begin
         mem_addr = pc_value + 8'd1;
      end
   end

   assign mem_req         = mem_req_q;
   assign pc_enable       = pc_enable_q;
   assign pc_jump         = pc_jump_q;
   assign pc_jz           = pc_jz_q;
   assign pc_jump_address = pc_jump_address_q;
   assign alu_op          = alu_op_q;
   assign reg_sel         = reg_sel_q;
   assign imm             = imm_q;
   assign reg_write       = reg_write_q;
   assign halted          = halted_q;
   assign fault           = fault_q;
   assign illegal         = illegal_q;
   assign retired_count   = retired_q;

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Instruction sequencer for the 8-bit CPU.
- Fetches 2-byte instructions from byte-wide program memory over a req/ready handshake, decodes them, and drives datapath write strobes.
- Controls the program counter (enable, jump, jz, jump address) once per retired instruction.
- Sits between program memory, the register file/ALU, and the program counter.

Parameters:
- TIMEOUT, 15, max cycles mem_req may wait for mem_ready before entering FAULT (legal range 1-255).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- run  input  1  level; 1 = execute, 0 = stop at instruction boundary
- pc_value  input  8  current PC (PC output, even, 0..126)
- mem_req  output  1  program memory read request
- mem_addr  output  8  program memory byte address
- mem_ready  input  1  read accepted; mem_rdata valid this cycle
- mem_rdata  input  8  program memory read data
- pc_enable  output  1  one-cycle PC advance strobe
- pc_jump  output  1  unconditional jump, valid with pc_enable
- pc_jz  output  1  jump-if-zero, valid with pc_enable
- pc_jump_address  output  8  jump target, valid with pc_enable
- alu_op  output  2  00 pass-imm, 01 add, 10 sub, 11 unused
- reg_sel  output  4  destination register (opcode byte bits 3:0)
- imm  output  8  operand byte
- reg_write  output  1  one-cycle register write strobe
- halted  output  1  HALT executed
- fault  output  1  memory timeout
- illegal  output  1  one-cycle pulse, undefined opcode
- retired_count  output  16  instructions retired, wraps 0xFFFF->0

Behaviour:
- Reset (async): state IDLE; every output 0. mem_req drops immediately, including mid-handshake.
- Instruction format:
  - byte[pc]: opcode in bits 7:4, reg in bits 3:0
  - byte[pc+1]: operand
- Opcodes: 0 NOP, 1 LDI, 2 ADD, 3 SUB, 4 JMP, 5 JZ, F HALT. Opcodes 6-E are illegal.
- States: IDLE, FETCH0, FETCH1, EXECUTE, ADVANCE, HALTED, FAULT.
- IDLE: outputs quiescent. run=1 -> FETCH0 next cycle.
- FETCH0:
  - mem_req=1, mem_addr=pc_value.
  - Cycle with mem_ready=1: latch mem_rdata as opcode byte, -> FETCH1.
- FETCH1:
  - mem_req=1, mem_addr=pc_value+1 (never exceeds 127).
  - On mem_ready=1: latch operand, -> EXECUTE.
- Handshake rules:
  - mem_req and mem_addr are held stable until the mem_ready cycle.
  - mem_req deasserts for at least one cycle between FETCH0 and FETCH1 only if mem_ready was high. Back-to-back requests are allowed; the address changes on the cycle after ready.
  - Zero-wait memory (mem_ready=1 in the first cycle) gives 1 cycle per fetch state.
- Timeout:
  - A wait counter resets on entry to each fetch state.
  - If TIMEOUT cycles elapse with mem_ready=0 -> FAULT.
  - A ready arriving on cycle TIMEOUT is still accepted.
- EXECUTE (1 cycle): imm, reg_sel and alu_op are driven from the latched bytes.
  - LDI: reg_write=1, alu_op=00.
  - ADD: reg_write=1, alu_op=01.
  - SUB: reg_write=1, alu_op=10.
  - NOP/JMP/JZ: no write.
  - HALT: -> HALTED, no PC advance, retired_count unchanged.
  - Illegal: illegal=1 this cycle, treated as NOP.
  - Otherwise -> ADVANCE.
- ADVANCE (1 cycle):
  - pc_enable=1.
  - pc_jump=1 for JMP; pc_jz=1 for JZ; both 0 otherwise.
  - pc_jump_address = operand with bit 0 cleared. It is 0 when not jumping.
  - retired_count increments.
  - -> FETCH0 if run=1, else IDLE.
  - The PC samples the zero flag itself; the controller does not gate pc_jz.
- Latency: 4 cycles per instruction with zero-wait memory, plus memory wait cycles.
- run falling mid-instruction: the current instruction completes through ADVANCE, then IDLE.
- HALTED and FAULT are sticky until reset; halted and fault are held at 1. No mem_req or pc_enable is issued in either state.
- Strobes: reg_write, pc_enable and illegal are never high for more than one consecutive cycle.

Test Plan:
- Reset then run=1, zero-wait memory: LDI r3,0x5A at 0x00 -> mem_addr 0x00 then 0x01. EXECUTE gives reg_write=1, reg_sel=3, imm=0x5A, alu_op=00. ADVANCE gives pc_enable=1 with jump/jz=0. retired_count=1. Total 4 cycles.
- JMP 0x21 at pc 0x10 -> pc_enable=1, pc_jump=1, pc_jump_address=0x20. The next FETCH0 uses the new pc_value.
- JZ 0x40 -> pc_jz=1, pc_jump=0, pc_jump_address=0x40. Opcode 0x7 -> illegal pulses once, no reg_write, PC advances normally.
- mem_ready delayed 3 cycles in FETCH1 -> mem_req/mem_addr held stable 4 cycles, instruction completes. With TIMEOUT=4 and ready never arriving -> fault=1 after 4 wait cycles, mem_req=0, sticky.
- HALT opcode 0xF0 -> halted=1, no pc_enable, retired_count unchanged. run toggling has no effect until reset.
- Reset asserted during FETCH1 wait -> mem_req and all outputs 0 immediately, state IDLE. run=0 mid-ADD -> ADD retires, then IDLE with no further mem_req.
